mips_cpu_regfile: RTL and testbench
===================================

# mips_cpu_regfile

General-purpose register file plus HI/LO pair: the write-side consumer of the writeback select mux, and the read-side source for the ALU and the memory address/data paths. It holds 32×32-bit GPRs with r0 hardwired to zero, one synchronous write port fed by the writeback mux, two asynchronous read ports with optional same-cycle write bypass, and HI/LO registers written by the multiply/divide unit. It also exports `register_v0` for testbench observation.

## Interface
- `BYPASS`, 1: 1 = a read of the register being written this cycle returns the write data; 0 = it returns the stored value.
- `clk`  in  1  system clock, all state updates on rising edge.
- `reset`  in  1  synchronous, active-high; one clock, one reset, synchronous active-high.
- `active`  in  1  CPU running; when 0, all writes are suppressed.
- `rs_addr`, `rt_addr`  in  5 each  read-port addresses.
- `rs_data`, `rt_data`  out  32 each  read-port data (combinational).
- `write_enable`  in  1  GPR write strobe from control.
- `write_addr`  in  5  destination register (rd, rt, or 31 for link).
- `write_data`  in  32  `reg_write_data` from the writeback mux.
- `hi_we`, `lo_we`  in  1 each  HI/LO write strobes.
- `hi_wdata`, `lo_wdata`  in  32 each  HI/LO write data.
- `hi_data`, `lo_data`  out  32 each  current HI/LO contents.
- `register_v0`  out  32  live copy of r2.

## Operation
- **GPR write:**
  - On a rising edge with `active && write_enable && write_addr != 0`, `regs[write_addr] <= write_data`.
  - A write to r0 is discarded.
  - r0 always reads 0, including through bypass.
- **Reads:** `rs_data = (rs_addr==0) ? 0 : regs[rs_addr]`; same rule for rt.
- **Bypass** (`BYPASS=1`): if `active && write_enable && write_addr==rs_addr && rs_addr!=0`, then `rs_data = write_data`. The same rule applies independently to rt. Both ports may bypass in the same cycle.
- **HI/LO:**
  - On a rising edge, `hi <= hi_wdata` when `active && hi_we`.
  - LO is independent and follows the same rule with `lo_we`/`lo_wdata`.
  - Simultaneous HI, LO and GPR writes are all legal and all take effect.
  - HI/LO read ports have no bypass. MTHI/MFHI ordering is the control unit's responsibility.
- **`register_v0`:** equals `regs[2]` (registered value, no bypass).
- **Reset:** when `reset` is high at a rising edge, all 31 GPRs, HI and LO are cleared to 0. Reset beats any concurrent write.
- **Inactive:** with `active=0`, no state changes at all. Reads still work and bypass is disabled.

## Timing
- Write latency: 1 cycle. Data is visible on a non-bypassed read in the cycle after the write edge.
- Read latency: 0 cycles (combinational from address and state).
- Reset values: `rs_data`/`rt_data` = 0 for any address, `hi_data = lo_data = register_v0 = 0`, all valid from the first edge with reset high.
- **Reset mid-operation:** a write presented in the same cycle as reset is lost. The next cycle reads 0.
- **Back-to-back writes** to the same register: the last edge wins. No write is ever merged.
- **Address wrap:** 5-bit addresses cover 0..31 fully. Out-of-range addresses do not exist.

## Structure
- Shared package `mips_cpu_pkg`:
  - `localparam REG_ZERO = 5'd0`, `REG_V0 = 5'd2`, `REG_RA = 5'd31`
  - `typedef logic [31:0] word_t`
  - `typedef logic [4:0] regaddr_t`
- Storage: an unpacked `word_t regs[31:1]` plus `hi`/`lo` flops. No r0 storage.
- One sub-module is natural: `mips_cpu_regfile_readport` (address, state array, write-bypass inputs → data), instantiated twice for rs and rt.
- HI/LO stay inline; they are two flops each with an enable.

## Test plan
- **Reset:** write r5 = 0xDEADBEEF, then assert reset for one cycle → r5 reads 0; HI, LO and `register_v0` read 0.
- **r0 protection:** `write_enable=1`, `write_addr=0`, `write_data=0xFFFFFFFF` → `rs_data` for address 0 is 0 both in the same cycle (bypass) and in the next cycle.
- **Bypass:**
  - With `BYPASS=1`, write r2 = 0x12345678 with `rs_addr=rt_addr=2` → both ports show 0x12345678 in the same cycle, while `register_v0` shows the old value until the edge.
  - With `BYPASS=0`, both ports show the old value until the edge.
- **Link write:** `write_addr=31`, `write_data=0x0000_1008` → r31 reads 0x1008 the next cycle; r30 is unchanged.
- **HI/LO:** `hi_we=1`, `lo_we=0`, `hi_wdata=0xA`, `lo_wdata=0xB` → HI=0xA and LO is unchanged. Then assert both strobes together with a GPR write to r7 → all three update on the same edge.
- **Inactive and reset priority:**
  - With `active=0`, GPR, HI and LO writes change nothing, checked over 5 cycles.
  - Reset asserted together with a write to r9 = 0x55 → r9 reads 0 afterwards.

Source files
------------

// File: rtl/mips_cpu_pkg.sv
// Shared types and fixed register numbers for the MIPS CPU datapath.
package mips_cpu_pkg;

    typedef logic [31:0] word_t;
    typedef logic [4:0]  regaddr_t;

    localparam regaddr_t REG_ZERO = 5'd0;
    localparam regaddr_t REG_V0   = 5'd2;
    localparam regaddr_t REG_RA   = 5'd31;

endpackage

// File: rtl/mips_cpu_regfile_readport.sv
// One asynchronous GPR read port with optional same-cycle write bypass; r0 reads as zero.
module mips_cpu_regfile_readport
    import mips_cpu_pkg::*;
#(
    parameter bit BYPASS = 1'b1
) (
    input  regaddr_t addr,
    input  word_t    regs [31:1],
    input  logic     wr_en,
    input  regaddr_t wr_addr,
    input  word_t    wr_data,
    output word_t    data
);

    always_comb begin
        data = '0;
        if (addr != REG_ZERO) begin
            for (int i = 1; i < 32; i++) begin
                if (addr == regaddr_t'(i)) begin
                    data = regs[i];
                end
            end
            // wr_en already carries the active qualifier, so inactive cycles never bypass
            if (BYPASS && wr_en && (wr_addr == addr)) begin
                data = wr_data;
            end
        end
    end

endmodule

// File: rtl/mips_cpu_regfile.sv
// 31x32 GPR file (r0 hardwired to zero) with two read ports, one write port and HI/LO.
module mips_cpu_regfile
    import mips_cpu_pkg::*;
#(
    parameter bit BYPASS = 1'b1
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     active,
    input  regaddr_t rs_addr,
    input  regaddr_t rt_addr,
    output word_t    rs_data,
    output word_t    rt_data,
    input  logic     write_enable,
    input  regaddr_t write_addr,
    input  word_t    write_data,
    input  logic     hi_we,
    input  logic     lo_we,
    input  word_t    hi_wdata,
    input  word_t    lo_wdata,
    output word_t    hi_data,
    output word_t    lo_data,
    output word_t    register_v0
);

    word_t regs_q [31:1];
    word_t regs_d [31:1];
    word_t hi_q, hi_d;
    word_t lo_q, lo_d;
    logic  gpr_wr;

    assign gpr_wr = active && write_enable && (write_addr != REG_ZERO);

    always_comb begin
        regs_d = regs_q;
        hi_d   = hi_q;
        lo_d   = lo_q;
        for (int i = 1; i < 32; i++) begin
            if (gpr_wr && (write_addr == regaddr_t'(i))) begin
                regs_d[i] = write_data;
            end
        end
        if (active && hi_we) begin
            hi_d = hi_wdata;
        end
        if (active && lo_we) begin
            lo_d = lo_wdata;
        end
    end

    // Reset overrides any write presented on the same edge
    always_ff @(posedge clk) begin
        if (reset) begin
            regs_q <= '{default: '0};
            hi_q   <= '0;
            lo_q   <= '0;
        end else begin
            regs_q <= regs_d;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
        end
    end

    mips_cpu_regfile_readport #(.BYPASS(BYPASS)) u_rs_port (
        .addr    (rs_addr),
        .regs    (regs_q),
        .wr_en   (gpr_wr),
        .wr_addr (write_addr),
        .wr_data (write_data),
        .data    (rs_data)
    );

    mips_cpu_regfile_readport #(.BYPASS(BYPASS)) u_rt_port (
        .addr    (rt_addr),
        .regs    (regs_q),
        .wr_en   (gpr_wr),
        .wr_addr (write_addr),
        .wr_data (write_data),
        .data    (rt_data)
    );

    assign hi_data     = hi_q;
    assign lo_data     = lo_q;
    assign register_v0 = regs_q[REG_V0];

endmodule

// File: tb/tb_mips_cpu_regfile.sv
// Directed bench for mips_cpu_regfile, with bypassing (a) and non-bypassing (b) instances side by side.
module tb_mips_cpu_regfile;

    logic        clk = 1'b0;
    logic        reset, active;
    logic [4:0]  rs_addr, rt_addr, write_addr;
    logic        write_enable, hi_we, lo_we;
    logic [31:0] write_data, hi_wdata, lo_wdata;

    logic [31:0] a_rs, a_rt, a_hi, a_lo, a_v0;
    logic [31:0] b_rs, b_rt, b_hi, b_lo, b_v0;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mips_cpu_regfile #(.BYPASS(1'b1)) dut_a (
        .clk(clk), .reset(reset), .active(active),
        .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_data(a_rs), .rt_data(a_rt),
        .write_enable(write_enable), .write_addr(write_addr), .write_data(write_data),
        .hi_we(hi_we), .lo_we(lo_we), .hi_wdata(hi_wdata), .lo_wdata(lo_wdata),
        .hi_data(a_hi), .lo_data(a_lo), .register_v0(a_v0)
    );

    mips_cpu_regfile #(.BYPASS(1'b0)) dut_b (
        .clk(clk), .reset(reset), .active(active),
        .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_data(b_rs), .rt_data(b_rt),
        .write_enable(write_enable), .write_addr(write_addr), .write_data(write_data),
        .hi_we(hi_we), .lo_we(lo_we), .hi_wdata(hi_wdata), .lo_wdata(lo_wdata),
        .hi_data(b_hi), .lo_data(b_lo), .register_v0(b_v0)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change and outputs settle mid-cycle
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic gpr_write(input logic [4:0] addr, input logic [31:0] data);
        write_enable = 1'b1;
        write_addr   = addr;
        write_data   = data;
        tick();
        write_enable = 1'b0;
        #1;
    endtask

    initial begin
        reset = 1'b1; active = 1'b1;
        rs_addr = '0; rt_addr = '0; write_addr = '0; write_enable = 1'b0;
        write_data = '0; hi_we = 1'b0; lo_we = 1'b0; hi_wdata = '0; lo_wdata = '0;
        tick();
        tick();
        reset = 1'b0;
        rs_addr = 5'd5; rt_addr = 5'd17;
        #1;
        chk("rst_rs", a_rs, 32'h0);
        chk("rst_rt", b_rt, 32'h0);
        chk("rst_hi", a_hi, 32'h0);
        chk("rst_v0", a_v0, 32'h0);

        // Populate state, then reset clears it all
        hi_we = 1'b1; lo_we = 1'b1; hi_wdata = 32'h1; lo_wdata = 32'h2;
        gpr_write(5'd5, 32'hDEADBEEF);
        hi_we = 1'b0; lo_we = 1'b0;
        gpr_write(5'd2, 32'h3);
        chk("r5_written", a_rs, 32'hDEADBEEF);
        chk("hi_written", a_hi, 32'h1);
        chk("v0_written", b_v0, 32'h3);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk("r5_after_rst", a_rs, 32'h0);
        chk("r5_after_rst_b", b_rs, 32'h0);
        chk("hi_after_rst", a_hi, 32'h0);
        chk("lo_after_rst", b_lo, 32'h0);
        chk("v0_after_rst", a_v0, 32'h0);

        // r0 protection, same cycle and next cycle
        rs_addr = 5'd0; rt_addr = 5'd0;
        write_enable = 1'b1; write_addr = 5'd0; write_data = 32'hFFFFFFFF;
        #1;
        chk("r0_byp_rs", a_rs, 32'h0);
        chk("r0_byp_rt", a_rt, 32'h0);
        tick();
        write_enable = 1'b0;
        #1;
        chk("r0_next_rs", a_rs, 32'h0);
        chk("r0_next_rs_b", b_rs, 32'h0);

        // Bypass vs no bypass on r2
        gpr_write(5'd2, 32'h11111111);
        rs_addr = 5'd2; rt_addr = 5'd2;
        write_enable = 1'b1; write_addr = 5'd2; write_data = 32'h12345678;
        #1;
        chk("byp_a_rs", a_rs, 32'h12345678);
        chk("byp_a_rt", a_rt, 32'h12345678);
        chk("byp_a_v0_old", a_v0, 32'h11111111);
        chk("nobyp_b_rs", b_rs, 32'h11111111);
        chk("nobyp_b_rt", b_rt, 32'h11111111);
        tick();
        write_enable = 1'b0;
        #1;
        chk("byp_a_v0_new", a_v0, 32'h12345678);
        chk("nobyp_b_rs_new", b_rs, 32'h12345678);

        // Independent ports: only rt matches the write
        rs_addr = 5'd2; rt_addr = 5'd12;
        write_enable = 1'b1; write_addr = 5'd12; write_data = 32'h0000C0DE;
        #1;
        chk("byp_rt_only_rs", a_rs, 32'h12345678);
        chk("byp_rt_only_rt", a_rt, 32'h0000C0DE);
        tick();
        write_enable = 1'b0;

        // Link write leaves r30 alone
        gpr_write(5'd30, 32'h0000CAFE);
        gpr_write(5'd31, 32'h00001008);
        rs_addr = 5'd31; rt_addr = 5'd30;
        #1;
        chk("link_r31", a_rs, 32'h00001008);
        chk("link_r30", b_rt, 32'h0000CAFE);

        // Back-to-back writes: last edge wins
        gpr_write(5'd3, 32'h1);
        gpr_write(5'd3, 32'h2);
        rs_addr = 5'd3;
        #1;
        chk("b2b_r3", b_rs, 32'h2);

        // HI/LO independence, then simultaneous HI, LO and GPR
        lo_we = 1'b1; lo_wdata = 32'h77;
        tick();
        lo_we = 1'b0;
        hi_we = 1'b1; hi_wdata = 32'hA; lo_wdata = 32'hB;
        tick();
        hi_we = 1'b0;
        #1;
        chk("hi_only_hi", a_hi, 32'hA);
        chk("hi_only_lo", a_lo, 32'h77);
        hi_we = 1'b1; lo_we = 1'b1; hi_wdata = 32'h100; lo_wdata = 32'h200;
        gpr_write(5'd7, 32'h700);
        hi_we = 1'b0; lo_we = 1'b0;
        rs_addr = 5'd7;
        #1;
        chk("both_hi", a_hi, 32'h100);
        chk("both_lo", b_lo, 32'h200);
        chk("both_r7", a_rs, 32'h700);

        // Inactive: no state change, no bypass
        active = 1'b0;
        write_enable = 1'b1; write_addr = 5'd7; write_data = 32'hBAD;
        hi_we = 1'b1; lo_we = 1'b1; hi_wdata = 32'hBAD1; lo_wdata = 32'hBAD2;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk($sformatf("inact_byp_rs%0d", c), a_rs, 32'h700);
            tick();
            chk($sformatf("inact_r7_%0d", c), b_rs, 32'h700);
            chk($sformatf("inact_hi_%0d", c), a_hi, 32'h100);
            chk($sformatf("inact_lo_%0d", c), a_lo, 32'h200);
        end
        active = 1'b1;
        write_enable = 1'b0; hi_we = 1'b0; lo_we = 1'b0;

        // Reset beats a concurrent write
        reset = 1'b1;
        write_enable = 1'b1; write_addr = 5'd9; write_data = 32'h55;
        tick();
        reset = 1'b0; write_enable = 1'b0;
        rs_addr = 5'd9; rt_addr = 5'd7;
        #1;
        chk("rst_prio_r9", a_rs, 32'h0);
        chk("rst_prio_r7", b_rt, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
